generador_obstaculos_param: RTL

//  Parametrised successor of the obstacle generator. Produces a game-rate tick whose

---
 rtl/generador_obstaculos_param_if.sv | 30 +++
 rtl/generador_obstaculos_param.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/generador_obstaculos_param_if.sv
// Game-side bundle for the obstacle generator: FSM/status inputs from the game,
// tick/world/display outputs towards display and collision logic.
interface generador_obstaculos_param_if #(
    parameter int NUM_SLOTS  = 3,
    parameter int SEG_W      = 7,
    parameter int LFSR_W     = 4,
    parameter int NUM_WORLDS = 3
);
    localparam int MUNDO_W = $clog2(NUM_WORLDS + 1);

    logic [2:0]               presente;
    logic [1:0]               W_or_L;
    logic                     bono_tomado;
    logic [SEG_W-1:0]         obstaculo;
    logic                     tick;
    logic [MUNDO_W-1:0]       mundo;
    logic [LFSR_W:0]          tipo_obs;
    logic [NUM_SLOTS*SEG_W-1:0] display_obs;
    logic                     seq_done;

    modport master (
        output presente, W_or_L, bono_tomado, obstaculo,
        input  tick, mundo, tipo_obs, display_obs, seq_done
    );

    modport slave (
        input  presente, W_or_L, bono_tomado, obstaculo,
        output tick, mundo, tipo_obs, display_obs, seq_done
    );
endinterface

// File: rtl/generador_obstaculos_param.sv
// World-paced obstacle sequencer feeding an N-slot scrolling display.
// Optional OBS_LFSR_RESEED_EN: seed each sequence from a free-running counter.
module generador_obstaculos_param #(
    parameter int                NUM_SLOTS  = 3,
    parameter int                SEG_W      = 7,
    parameter int                LFSR_W     = 4,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 4'b1101,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_W'(1),
    parameter int                NUM_WORLDS = 3,
    parameter int                BASE_COUNT = 15,
    parameter int                COUNT_STEP = 5,
    parameter int                GAP        = 1,
    parameter int                DIV_BASE   = 18000000,
    parameter int                DIV_DEC    = 2700000,
    parameter logic [2:0]        GAME       = 3'd3
) (
    input logic clk,
    input logic rst,
    generador_obstaculos_param_if.slave bus
);
    localparam int MUNDO_W  = $clog2(NUM_WORLDS + 1);
    localparam int CONTEO_W = $clog2(BASE_COUNT + NUM_WORLDS * COUNT_STEP + 1);
    localparam int PHASE_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int CNT_W    = (DIV_BASE > 2) ? $clog2(DIV_BASE) : 1;
    localparam int DISP_W   = NUM_SLOTS * SEG_W;

    typedef enum logic [1:0] {IDLE, EMIT, BONUS, DONE} state_t;

    logic [CNT_W-1:0]   cnt;
    logic [MUNDO_W-1:0] mundo;
    logic               bono_q;
    logic [31:0]        div_m1;
    logic               tick_i;
    logic               mundo_adv;
    logic               qtick;

    assign div_m1    = 32'(DIV_BASE) - 32'(DIV_DEC) * 32'(mundo) - 32'd1;
    assign tick_i    = (32'(cnt) == div_m1);
    assign mundo_adv = bus.bono_tomado && !bono_q && (mundo < MUNDO_W'(NUM_WORLDS));
    assign qtick     = tick_i && (bus.presente == GAME) && (bus.W_or_L == 2'b00);

    // The world update and the counter clear land on the same edge, so a tick in
    // the edge cycle still belongs to the old period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            mundo  <= '0;
            bono_q <= 1'b0;
        end else begin
            bono_q <= bus.bono_tomado;
            if (mundo_adv) begin
                mundo <= mundo + MUNDO_W'(1);
                cnt   <= '0;
            end else if (tick_i) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    logic [LFSR_W-1:0] seed;
`ifdef OBS_LFSR_RESEED_EN
    logic [LFSR_W-1:0] seed_cnt;

    always_ff @(posedge clk) begin
        if (rst)            seed_cnt <= LFSR_W'(1);
        else if (&seed_cnt) seed_cnt <= LFSR_W'(1);
        else                seed_cnt <= seed_cnt + LFSR_W'(1);
    end

    assign seed = seed_cnt;
`else
    assign seed = LFSR_SEED;
`endif

    state_t              state, state_d;
    logic [DISP_W-1:0]   display, display_d;
    logic [CONTEO_W-1:0] conteo, conteo_d;
    logic [PHASE_W-1:0]  phase, phase_d;
    logic [LFSR_W-1:0]   lfsr, lfsr_d, lfsr_step;
    logic [LFSR_W:0]     tipo, tipo_d;
    logic [MUNDO_W-1:0]  seq_mundo, seq_mundo_d;
    logic [SEG_W-1:0]    top;

    always_comb begin
        lfsr_step = {^(lfsr & LFSR_TAPS), lfsr[LFSR_W-1:1]};
        if (lfsr_step == '0) lfsr_step = LFSR_W'(1);
    end

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state;
        display_d   = display;
        conteo_d    = conteo;
        phase_d     = phase;
        lfsr_d      = lfsr;
        tipo_d      = tipo;
        seq_mundo_d = seq_mundo;
        top         = '0;

        if (bus.presente != GAME) begin
            state_d   = IDLE;
            display_d = '0;
        end else if (qtick) begin
            unique case (state)
                IDLE: begin
                    if (mundo < MUNDO_W'(NUM_WORLDS)) begin
                        conteo_d    = CONTEO_W'(BASE_COUNT + COUNT_STEP * int'(mundo));
                        lfsr_d      = (seed == '0) ? LFSR_W'(1) : seed;
                        phase_d     = '0;
                        seq_mundo_d = mundo;
                        state_d     = EMIT;
                    end
                end
                EMIT: begin
                    if (phase == '0) begin
                        top      = bus.obstaculo;
                        tipo_d   = {1'b0, lfsr};
                        conteo_d = conteo - CONTEO_W'(1);
                    end
                    if (phase == PHASE_W'(GAP)) begin
                        phase_d = '0;
                        lfsr_d  = lfsr_step;
                        if (conteo_d == '0) state_d = BONUS;
                    end else begin
                        phase_d = phase + PHASE_W'(1);
                    end
                end
                BONUS: begin
                    top     = bus.obstaculo;
                    tipo_d  = {1'b1, {LFSR_W{1'b0}}};
                    state_d = DONE;
                end
                DONE: begin
                    // A world change is seen by comparing against the world that was played.
                    if ((mundo != seq_mundo) && (mundo < MUNDO_W'(NUM_WORLDS))) state_d = IDLE;
                end
            endcase
            display_d = {top, display[DISP_W-1:SEG_W]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; combinational logic above uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            display   <= '0;
            conteo    <= '0;
            phase     <= '0;
            lfsr      <= LFSR_SEED;
            tipo      <= '0;
            seq_mundo <= '0;
        end else begin
            state     <= state_d;
            display   <= display_d;
            conteo    <= conteo_d;
            phase     <= phase_d;
            lfsr      <= lfsr_d;
            tipo      <= tipo_d;
            seq_mundo <= seq_mundo_d;
        end
    end

    assign bus.tick        = tick_i;
    assign bus.mundo       = mundo;
    assign bus.tipo_obs    = tipo;
    assign bus.display_obs = display;
    assign bus.seq_done    = (state == DONE);
endmodule
